class_oftcam_pio: RTL and testbench

PIO initiator for the classifier overflow TCAM. Accepts single host register requests on a valid/ready channel, drives the TCAM's `pio_oftcam_rd`/`pio_oftcam_wr` strobe interface, and waits for `oftcam_pio_ack`. It then returns read data and a status code on a response channel held until the host accepts it. It sits between the classifier PIO decoder and the overflow TCAM, one transaction outstanding.

---
 rtl/class_pkg.sv | 20 ++
 rtl/class_oftcam_pio_tmr.sv | 33 +++
 rtl/class_oftcam_pio.sv | 164 ++++++++++++++++
 tb/tb_class_oftcam_pio.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/class_pkg.sv
// Shared types for the classifier overflow-TCAM PIO initiator: FSM states,
// response status codes and the entry word-count helper.
package class_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ADDR    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic int unsigned key_words(input int unsigned key_len);
    return (key_len + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/class_oftcam_pio_tmr.sv
// Ack-wait timeout counter: cleared before WAIT, counts while enabled,
// saturates at TIMEOUT_CYCLES and flags done at TIMEOUT_CYCLES-1.
module class_oftcam_pio_tmr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/class_oftcam_pio.sv
// PIO initiator for the classifier overflow TCAM, one transaction in flight.
// Define CLASS_OFTCAM_PIO_TIMEOUT_EN to enable the ack-wait timeout.
module class_oftcam_pio
  import class_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned KEY_LEN        = 276,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wrdata,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_rddata,
  output logic [1:0]  rsp_err,
  output logic        pio_oftcam_rd,
  output logic        pio_oftcam_wr,
  output logic [15:0] pio_oftcam_addr,
  output logic [31:0] pio_oftcam_wrdata,
  input  logic        oftcam_pio_ack,
  input  logic [31:0] oftcam_pio_rddata,
  output logic        stray_ack
);

  localparam int unsigned KEY_WORDS  = key_words(KEY_LEN);
  localparam int unsigned ADDR_LIMIT = DEPTH * KEY_WORDS;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic        req_rdy_q, req_rdy_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_rddata_q, rsp_rddata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        stray_q, stray_d;
  logic        tmo_done;
  logic        addr_ok;

  assign addr_ok = ({16'd0, req_addr} < 32'(ADDR_LIMIT));

`ifdef CLASS_OFTCAM_PIO_TIMEOUT_EN
  class_oftcam_pio_tmr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == ST_ISSUE),
    .en   ((state_q == ST_WAIT) && !oftcam_pio_ack),
    .done (tmo_done)
  );
`else
  assign tmo_done = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_rdy_d    = req_rdy_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_rddata_d = rsp_rddata_q;
    rsp_err_d    = rsp_err_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    stray_d      = stray_q | (oftcam_pio_ack && (state_q != ST_WAIT));

    unique case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          req_rdy_d = 1'b0;
          is_wr_d   = req_wr;
          addr_d    = req_addr;
          wrdata_d  = req_wrdata;
          if (addr_ok) begin
            // Strobe is registered here so it lands exactly in the ISSUE cycle.
            rd_d    = !req_wr;
            wr_d    = req_wr;
            state_d = ST_ISSUE;
          end else begin
            rsp_vld_d    = 1'b1;
            rsp_err_d    = ERR_ADDR;
            rsp_rddata_d = '0;
            state_d      = ST_RESP;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Ack has priority over a timeout firing in the same cycle.
        if (oftcam_pio_ack) begin
          rsp_vld_d    = 1'b1;
          rsp_err_d    = ERR_OK;
          rsp_rddata_d = is_wr_q ? 32'd0 : oftcam_pio_rddata;
          state_d      = ST_RESP;
        end else if (tmo_done) begin
          rsp_vld_d    = 1'b1;
          rsp_err_d    = ERR_TIMEOUT;
          rsp_rddata_d = '0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          req_rdy_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_rdy_q    <= 1'b1;
      rsp_vld_q    <= 1'b0;
      rsp_rddata_q <= '0;
      rsp_err_q    <= ERR_OK;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_rdy_q    <= req_rdy_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_rddata_q <= rsp_rddata_d;
      rsp_err_q    <= rsp_err_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
      stray_q      <= stray_d;
    end
  end

  assign req_rdy           = req_rdy_q;
  assign rsp_vld           = rsp_vld_q;
  assign rsp_rddata        = rsp_rddata_q;
  assign rsp_err           = rsp_err_q;
  assign pio_oftcam_rd     = rd_q;
  assign pio_oftcam_wr     = wr_q;
  assign pio_oftcam_addr   = addr_q;
  assign pio_oftcam_wrdata = wrdata_q;
  assign stray_ack         = stray_q;

endmodule

// File: tb/tb_class_oftcam_pio.sv
// Directed bench for class_oftcam_pio with a response scoreboard.
// Timeout scenarios run only when CLASS_OFTCAM_PIO_TIMEOUT_EN is defined.
module tb_class_oftcam_pio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wrdata = '0;
  logic        req_rdy, rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_rddata;
  logic [1:0]  rsp_err;
  logic        pio_oftcam_rd, pio_oftcam_wr;
  logic [15:0] pio_oftcam_addr;
  logic [31:0] pio_oftcam_wrdata;
  logic        oftcam_pio_ack = 1'b0;
  logic [31:0] oftcam_pio_rddata = '0;
  logic        stray_ack;

  typedef struct packed {
    logic [31:0] rddata;
    logic [1:0]  err;
  } rsp_t;

  rsp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  class_oftcam_pio #(
    .DEPTH(8), .KEY_LEN(276), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_rddata(rsp_rddata), .rsp_err(rsp_err),
    .pio_oftcam_rd(pio_oftcam_rd), .pio_oftcam_wr(pio_oftcam_wr),
    .pio_oftcam_addr(pio_oftcam_addr), .pio_oftcam_wrdata(pio_oftcam_wrdata),
    .oftcam_pio_ack(oftcam_pio_ack), .oftcam_pio_rddata(oftcam_pio_rddata),
    .stray_ack(stray_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_rsp(input string tag);
    rsp_t e;
    checks++;
    assert (sb_q.size() != 0)
    else begin
      failures++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rddata"}, rsp_rddata, e.rddata);
      chk({tag, "_err"}, {30'd0, rsp_err}, {30'd0, e.err});
    end
  endtask

  task automatic accept_rsp(input string tag);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk({tag, "_rsp_drop"}, {31'd0, rsp_vld}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, req_rdy}, 32'd1);
  endtask

  // Full transaction: ack arrives 'dly' cycles after the strobe (dly>=1).
  task automatic do_txn(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input int dly, input logic [31:0] ack_data);
    rsp_t e;
    e.rddata = wr ? 32'd0 : ack_data;
    e.err    = 2'd0;
    sb_q.push_back(e);
    chk({tag, "_req_rdy"}, {31'd0, req_rdy}, 32'd1);
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wrdata = wdata;
    tick();
    req_vld = 1'b0; req_addr = 16'hFFFF; req_wrdata = 32'h0BAD_0BAD;
    chk({tag, "_rd_strobe"}, {31'd0, pio_oftcam_rd}, {31'd0, !wr});
    chk({tag, "_wr_strobe"}, {31'd0, pio_oftcam_wr}, {31'd0, wr});
    chk({tag, "_rdy_low"}, {31'd0, req_rdy}, 32'd0);
    tick();
    for (int i = 1; i < dly; i++) begin
      chk({tag, "_no_strobe"}, {30'd0, pio_oftcam_rd, pio_oftcam_wr}, 32'd0);
      chk({tag, "_no_rsp"}, {31'd0, rsp_vld}, 32'd0);
      tick();
    end
    chk({tag, "_addr_hold"}, {16'd0, pio_oftcam_addr}, {16'd0, addr});
    chk({tag, "_wdata_hold"}, pio_oftcam_wrdata, wdata);
    oftcam_pio_ack = 1'b1; oftcam_pio_rddata = ack_data;
    tick();
    oftcam_pio_ack = 1'b0; oftcam_pio_rddata = '0;
    chk({tag, "_rsp_vld"}, {31'd0, rsp_vld}, 32'd1);
    pop_rsp(tag);
  endtask

  initial begin
    rsp_t e;
    logic [31:0] held;
    #12;
    chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_strobes", {30'd0, pio_oftcam_rd, pio_oftcam_wr}, 32'd0);
    chk("rst_addr", {16'd0, pio_oftcam_addr}, 32'd0);
    chk("rst_stray", {31'd0, stray_ack}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_txn("rd5", 1'b0, 16'd5, 32'd0, 3, 32'hA5A5_1234);
    accept_rsp("rd5");

    do_txn("wr71", 1'b1, 16'd71, 32'hDEAD_BEEF, 1, 32'h1234_5678);
    accept_rsp("wr71");

    e.rddata = 32'd0; e.err = 2'd1;
    sb_q.push_back(e);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'd72;
    tick();
    req_vld = 1'b0;
    chk("addr72_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("addr72_no_strobe", {30'd0, pio_oftcam_rd, pio_oftcam_wr}, 32'd0);
    pop_rsp("addr72");
    accept_rsp("addr72");

    // Host stalls the response while pushing another request.
    do_txn("hold", 1'b0, 16'd40, 32'd0, 2, 32'h0F0F_5A5A);
    held = rsp_rddata;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'd3; req_wrdata = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rsp_vld", {31'd0, rsp_vld}, 32'd1);
      chk("hold_rddata", rsp_rddata, held);
      chk("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
      chk("hold_no_strobe", {30'd0, pio_oftcam_rd, pio_oftcam_wr}, 32'd0);
    end
    req_vld = 1'b0;
    accept_rsp("hold");
    tick();
    chk("hold_not_taken", {30'd0, pio_oftcam_rd, pio_oftcam_wr}, 32'd0);

`ifdef CLASS_OFTCAM_PIO_TIMEOUT_EN
    e.rddata = 32'd0; e.err = 2'd2;
    sb_q.push_back(e);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'd9;
    tick();
    req_vld = 1'b0;
    chk("tmo_strobe", {31'd0, pio_oftcam_rd}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmo_wait", {31'd0, rsp_vld}, 32'd0);
    end
    tick();
    chk("tmo_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    pop_rsp("tmo");
    oftcam_pio_ack = 1'b1; oftcam_pio_rddata = 32'hCAFE_0000;
    tick();
    oftcam_pio_ack = 1'b0;
    chk("tmo_late_stray", {31'd0, stray_ack}, 32'd1);
    chk("tmo_rsp_kept", {31'd0, rsp_vld}, 32'd1);
    accept_rsp("tmo");
    do_txn("after_tmo", 1'b0, 16'd10, 32'd0, 2, 32'h7777_8888);
    accept_rsp("after_tmo");
`else
    do_txn("long_wait", 1'b0, 16'd20, 32'd0, 21, 32'h3C3C_C3C3);
    accept_rsp("long_wait");
    oftcam_pio_ack = 1'b1;
    tick();
    oftcam_pio_ack = 1'b0;
    chk("idle_stray", {31'd0, stray_ack}, 32'd1);
    chk("idle_ack_no_rsp", {31'd0, rsp_vld}, 32'd0);
`endif

    // Reset while waiting for ack.
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'd11;
    tick();
    req_vld = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_strobes", {30'd0, pio_oftcam_rd, pio_oftcam_wr}, 32'd0);
    chk("mrst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("mrst_req_rdy", {31'd0, req_rdy}, 32'd1);
    chk("mrst_stray", {31'd0, stray_ack}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    oftcam_pio_ack = 1'b1; oftcam_pio_rddata = 32'hFFFF_0001;
    tick();
    oftcam_pio_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mrst_no_rsp", {31'd0, rsp_vld}, 32'd0);
      tick();
    end
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
